// File: rtl/ifu_pc_ctrl.sv
// Fetch PC owner and I-fetch request sequencer.
// Selects next PC from flush / prediction / JALR resolve / +4 and tracks stale responses after flushes.
module ifu_pc_ctrl #(
   parameter int unsigned          ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]    RESET_PC = '0,
   parameter int unsigned          MAX_OUT  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_valid,
   input  logic [ADDR_W-1:0] flush_pc,
   input  logic              stall,
   input  logic              bpu_taken,
   input  logic [ADDR_W-1:0] bpu_target,
   input  logic              jalr_wait,
   input  logic              exu_jalr_valid,
   input  logic [ADDR_W-1:0] exu_jalr_pc,
   output logic              ifetch_req_valid,
   output logic [ADDR_W-1:0] ifetch_req_addr,
   input  logic              ifetch_req_ready,
   input  logic              ifetch_rsp_valid,
   output logic              rsp_drop,
   output logic [ADDR_W-1:0] pc_o,
   output logic              jalr_busy
);

   localparam int unsigned       CNT_W      = $clog2(MAX_OUT + 1);
   localparam logic [CNT_W-1:0]  MAX_CNT    = CNT_W'(MAX_OUT);
   localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(1);
   localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);

   typedef enum logic [1:0] {
      S_BOOT,
      S_RUN,
      S_JALR_WAIT
   } state_e;

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
   logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
   logic               req_valid;
   logic               req_fire;

   // No bypass: a full outstanding count blocks the request even if a response returns this cycle.
   always_comb begin
      req_valid = (state_q == S_RUN) & ~stall & ~flush_valid & ~jalr_wait & ~bpu_taken
                  & (out_cnt_q < MAX_CNT);
      req_fire  = req_valid & ifetch_req_ready;
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      unique case (state_q)
         S_BOOT: begin
            state_d = S_RUN;
            if (flush_valid) begin
               pc_d = flush_pc & ALIGN_MASK;
            end
         end
         S_RUN: begin
            if (flush_valid) begin
               pc_d = flush_pc & ALIGN_MASK;
            end else if (stall) begin
               pc_d = pc_q;
            end else if (bpu_taken) begin
               pc_d = bpu_target & ALIGN_MASK;
            end else if (jalr_wait) begin
               state_d = S_JALR_WAIT;
            end else if (req_fire) begin
               pc_d = pc_q + PC_STEP;
            end
         end
         S_JALR_WAIT: begin
            if (flush_valid) begin
               pc_d    = flush_pc & ALIGN_MASK;
               state_d = S_RUN;
            end else if (exu_jalr_valid) begin
               pc_d    = exu_jalr_pc & ALIGN_MASK;
               state_d = S_RUN;
            end
         end
         default: begin
            state_d = S_BOOT;
            pc_d    = RESET_PC;
         end
      endcase
   end

   // A response without anything outstanding is a protocol error; the count saturates at zero.
   always_comb begin
      out_cnt_d = out_cnt_q;
      unique case ({req_fire, ifetch_rsp_valid})
         2'b10:   out_cnt_d = out_cnt_q + CNT_ONE;
         2'b01:   out_cnt_d = (out_cnt_q != '0) ? out_cnt_q - CNT_ONE : '0;
         default: out_cnt_d = out_cnt_q;
      endcase
   end

   // The response arriving in the flush cycle is dropped directly, so it is not counted again.
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (flush_valid) begin
         if (ifetch_rsp_valid && (out_cnt_q != '0)) begin
            drop_cnt_d = out_cnt_q - CNT_ONE;
         end else begin
            drop_cnt_d = out_cnt_q;
         end
      end else if (ifetch_rsp_valid && (drop_cnt_q != '0)) begin
         drop_cnt_d = drop_cnt_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_BOOT;
         pc_q       <= RESET_PC;
         out_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         out_cnt_q  <= out_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign ifetch_req_valid = req_valid;
   assign ifetch_req_addr  = pc_q;
   assign pc_o             = pc_q;
   assign jalr_busy        = (state_q == S_JALR_WAIT);
   assign rsp_drop         = ifetch_rsp_valid & ((drop_cnt_q != '0) | flush_valid);

endmodule

// File: tb/tb_ifu_pc_ctrl.sv
// Directed bench for ifu_pc_ctrl: expected fetch addresses are queued as stimulus is driven
// and popped by a monitor on each observed request handshake.
module tb_ifu_pc_ctrl;

   logic        clk;
   logic        rst;
   logic        flush_valid;
   logic [31:0] flush_pc;
   logic        stall;
   logic        bpu_taken;
   logic [31:0] bpu_target;
   logic        jalr_wait;
   logic        exu_jalr_valid;
   logic [31:0] exu_jalr_pc;
   logic        ifetch_req_valid;
   logic [31:0] ifetch_req_addr;
   logic        ifetch_req_ready;
   logic        ifetch_rsp_valid;
   logic        rsp_drop;
   logic [31:0] pc_o;
   logic        jalr_busy;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q[$];

   ifu_pc_ctrl #(
      .ADDR_W   (32),
      .RESET_PC (32'h0000_0000),
      .MAX_OUT  (2)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .flush_valid      (flush_valid),
      .flush_pc         (flush_pc),
      .stall            (stall),
      .bpu_taken        (bpu_taken),
      .bpu_target       (bpu_target),
      .jalr_wait        (jalr_wait),
      .exu_jalr_valid   (exu_jalr_valid),
      .exu_jalr_pc      (exu_jalr_pc),
      .ifetch_req_valid (ifetch_req_valid),
      .ifetch_req_addr  (ifetch_req_addr),
      .ifetch_req_ready (ifetch_req_ready),
      .ifetch_rsp_valid (ifetch_rsp_valid),
      .rsp_drop         (rsp_drop),
      .pc_o             (pc_o),
      .jalr_busy        (jalr_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // Handshake monitor: every accepted request must match the oldest queued address.
   always @(negedge clk) begin
      if (!rst && ifetch_req_valid && ifetch_req_ready) begin
         n_checks++;
         assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL req_unexpected: observed addr %h expected no request", ifetch_req_addr);
         end
         if (exp_q.size() != 0) begin
            check("req_addr", ifetch_req_addr, exp_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected test completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; flush_valid = 1'b0; flush_pc = '0; stall = 1'b0;
      bpu_taken = 1'b0; bpu_target = '0; jalr_wait = 1'b0;
      exu_jalr_valid = 1'b0; exu_jalr_pc = '0;
      ifetch_req_ready = 1'b0; ifetch_rsp_valid = 1'b0;
      nxt(); nxt();
      settle();
      check("rst_pc", pc_o, 32'h0);
      check("rst_req_valid", ifetch_req_valid, 0);
      check("rst_rsp_drop", rsp_drop, 0);
      check("rst_jalr_busy", jalr_busy, 0);
      nxt();

      // T1: one BOOT cycle, then 0x0, 0x4, 0x8 back to back
      rst = 1'b0; ifetch_req_ready = 1'b1;
      exp_q.push_back(32'h0);
      settle(); check("t1_boot_no_req", ifetch_req_valid, 0); nxt();
      settle(); check("t1_run_req", ifetch_req_valid, 1); nxt();
      exp_q.push_back(32'h4); ifetch_rsp_valid = 1'b1;
      settle(); nxt();
      exp_q.push_back(32'h8);
      settle(); check("t1_rsp_not_dropped", rsp_drop, 0); nxt();
      ifetch_req_ready = 1'b0;
      settle(); check("t1_pc", pc_o, 32'hC); nxt();
      ifetch_rsp_valid = 1'b0;

      // T2: outstanding limit of 2 with no responses, no bypass on return
      ifetch_req_ready = 1'b1;
      exp_q.push_back(32'hC); exp_q.push_back(32'h10);
      settle(); nxt();
      settle(); nxt();
      settle(); check("t2_full_block", ifetch_req_valid, 0); nxt();
      settle(); check("t2_full_block2", ifetch_req_valid, 0); nxt();
      ifetch_rsp_valid = 1'b1;
      settle(); check("t2_no_bypass", ifetch_req_valid, 0); nxt();
      ifetch_rsp_valid = 1'b0; exp_q.push_back(32'h14);
      settle(); nxt();
      ifetch_req_ready = 1'b0; ifetch_rsp_valid = 1'b1;
      settle(); check("t2_full_again", ifetch_req_valid, 0); nxt();
      settle(); check("t2_room_again", ifetch_req_valid, 1); nxt();
      ifetch_rsp_valid = 1'b0;

      // T3: predicted-taken branch with odd target
      flush_valid = 1'b1; flush_pc = 32'h100;
      settle(); check("t3_flush_no_req", ifetch_req_valid, 0); nxt();
      flush_valid = 1'b0; bpu_taken = 1'b1; bpu_target = 32'h41; ifetch_req_ready = 1'b1;
      settle(); check("t3_bpu_no_req", ifetch_req_valid, 0); check("t3_pc_before", pc_o, 32'h100); nxt();
      bpu_taken = 1'b0; exp_q.push_back(32'h40);
      settle(); check("t3_pc_target", pc_o, 32'h40); nxt();
      ifetch_req_ready = 1'b0; ifetch_rsp_valid = 1'b1;
      settle(); check("t3_pc_next", pc_o, 32'h44); check("t3_rsp_drop", rsp_drop, 0); nxt();
      ifetch_rsp_valid = 1'b0;

      // T4: JALR wait and resolve
      flush_valid = 1'b1; flush_pc = 32'h200;
      settle(); nxt();
      flush_valid = 1'b0; jalr_wait = 1'b1; ifetch_req_ready = 1'b1;
      settle(); check("t4_jw_no_req", ifetch_req_valid, 0); check("t4_busy_pre", jalr_busy, 0); nxt();
      jalr_wait = 1'b0; stall = 1'b1;
      settle(); check("t4_busy", jalr_busy, 1); check("t4_wait_no_req", ifetch_req_valid, 0);
      check("t4_pc_hold", pc_o, 32'h200); nxt();
      stall = 1'b0; exu_jalr_valid = 1'b1; exu_jalr_pc = 32'h1235;
      settle(); check("t4_busy_resolve", jalr_busy, 1); nxt();
      exu_jalr_valid = 1'b0; exp_q.push_back(32'h1234);
      settle(); check("t4_busy_clear", jalr_busy, 0); nxt();

      // T5: flush with two outstanding drops exactly the next two responses
      exp_q.push_back(32'h1238);
      settle(); nxt();
      ifetch_req_ready = 1'b0; flush_valid = 1'b1; flush_pc = 32'h800;
      settle(); check("t5_flush_no_rsp", rsp_drop, 0); check("t5_flush_no_req", ifetch_req_valid, 0); nxt();
      flush_valid = 1'b0; ifetch_rsp_valid = 1'b1; ifetch_req_ready = 1'b1;
      settle(); check("t5_drop1", rsp_drop, 1); check("t5_full_block", ifetch_req_valid, 0); nxt();
      exp_q.push_back(32'h800);
      settle(); check("t5_drop2", rsp_drop, 1); nxt();
      ifetch_req_ready = 1'b0;
      settle(); check("t5_third_kept", rsp_drop, 0); nxt();
      ifetch_rsp_valid = 1'b0;

      // Flush with a response in the same cycle: that one is dropped, nothing older remains
      ifetch_req_ready = 1'b1; exp_q.push_back(32'h804);
      settle(); nxt();
      ifetch_req_ready = 1'b0; flush_valid = 1'b1; flush_pc = 32'h900; ifetch_rsp_valid = 1'b1;
      settle(); check("fr_drop_same_cycle", rsp_drop, 1); nxt();
      flush_valid = 1'b0; ifetch_rsp_valid = 1'b0; ifetch_req_ready = 1'b1; exp_q.push_back(32'h900);
      settle(); nxt();
      ifetch_req_ready = 1'b0; ifetch_rsp_valid = 1'b1;
      settle(); check("fr_later_kept", rsp_drop, 0); nxt();
      ifetch_rsp_valid = 1'b0;

      // T6: flush beats stall and prediction; flush out of JALR_WAIT
      flush_valid = 1'b1; flush_pc = 32'hA01; stall = 1'b1; bpu_taken = 1'b1; bpu_target = 32'h50;
      settle(); check("t6_no_req", ifetch_req_valid, 0); nxt();
      flush_valid = 1'b0; stall = 1'b0; bpu_taken = 1'b0; jalr_wait = 1'b1;
      settle(); check("t6_flush_pc", pc_o, 32'hA00); nxt();
      jalr_wait = 1'b0; flush_valid = 1'b1; flush_pc = 32'hB00;
      settle(); check("t6_busy", jalr_busy, 1); nxt();
      flush_valid = 1'b0; ifetch_req_ready = 1'b1; exp_q.push_back(32'hB00);
      settle(); check("t6_jw_flush_run", jalr_busy, 0); check("t6_jw_flush_pc", pc_o, 32'hB00); nxt();
      stall = 1'b1;
      settle(); check("t6_stall_no_req", ifetch_req_valid, 0); nxt();
      stall = 1'b0; ifetch_req_ready = 1'b0;
      settle(); check("t6_stall_hold", pc_o, 32'hB04); nxt();

      // Mid-run reset, late response not dropped, count saturates at zero
      rst = 1'b1;
      settle(); nxt();
      ifetch_rsp_valid = 1'b1;
      settle(); check("mr_pc", pc_o, 32'h0); check("mr_busy", jalr_busy, 0);
      check("mr_req", ifetch_req_valid, 0); check("mr_late_rsp", rsp_drop, 0); nxt();
      rst = 1'b0;
      settle(); check("mr_boot_rsp", rsp_drop, 0); nxt();
      ifetch_rsp_valid = 1'b0; ifetch_req_ready = 1'b1; exp_q.push_back(32'h0);
      settle(); check("sat_req_ok", ifetch_req_valid, 1); nxt();
      ifetch_req_ready = 1'b0; ifetch_rsp_valid = 1'b1;
      settle(); nxt();
      ifetch_rsp_valid = 1'b0; flush_valid = 1'b1; flush_pc = 32'hFFFF_FFFC;
      settle(); nxt();

      // PC wraps modulo 2^32
      flush_valid = 1'b0; ifetch_req_ready = 1'b1;
      exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
      settle(); nxt();
      settle(); nxt();
      ifetch_req_ready = 1'b0;
      settle(); check("wrap_pc", pc_o, 32'h4); check("wrap_full", ifetch_req_valid, 0); nxt();

      check("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
